lmc1992_rx: RTL
===============

// Module: lmc1992_rx
// PURPOSE
//  Microwire slave that receives STE sound-control frames and applies master/L/R volume to DMA audio.
//  Decodes 11-bit LMC1992 commands and holds the volume/tone/mixer register file.
//  Attenuates the unsigned 8-bit samples on audio_left/audio_right and outputs signed 16-bit samples.
// PARAMETERS
//  SYNC_STAGES  2   flip-flop synchronizer depth on MWCLK/MWDATA/MWEN_N (min 2)
//  ADDR_CODE    2'b10  device address required in frame bits [10:9]
// PORTS
//  clk32        in   1   system clock, all logic on posedge
//  resb         in   1   reset, asynchronous, active-low
//  MWCLK        in   1   microwire clock (async); data sampled on its rising edge
//  MWDATA       in   1   microwire serial data, MSB first
//  MWEN_N       in   1   microwire frame enable, low = frame active
//  audio_stb    in   1   one-cycle pulse, audio_in_l/r valid
//  audio_in_l   in   8   left sample, offset-binary (128 = zero)
//  audio_in_r   in   8   right sample, offset-binary
//  audio_out_l  out  16  left attenuated sample, two's complement
//  audio_out_r  out  16  right attenuated sample, two's complement
//  audio_vld    out  1   one-cycle pulse, audio_out_l/r updated
//  master_vol   out  6   0..40, 2 dB steps, 40 = 0 dB
//  left_vol     out  5   0..20, 20 = 0 dB
//  right_vol    out  5   0..20
//  bass         out  4   0..12, 6 = flat (status only, not applied)
//  treble       out  4   0..12, 6 = flat (status only)
//  mix          out  2   mixer select (status only)
//  cmd_stb      out  1   one-cycle pulse on each accepted command
// BEHAVIOUR
//  Reset: master_vol=40, left_vol=right_vol=20, bass=treble=6, mix=1, outputs/pulses 0, frame aborted.
//  Inputs pass through the SYNC_STAGES synchronizer, then edge detection on the synchronized copies.
//  Frame start: sync MWEN_N falling clears bit count (5b, saturates at 31) and the 11b shift reg.
//  Bit: sync MWCLK rising while MWEN_N low -> sr <= {sr[9:0],MWDATA}, cnt++.
//  MWCLK edges while MWEN_N high are ignored.
//  Frame end: sync MWEN_N rising. The frame is accepted iff cnt>=11 and sr[10:9]==ADDR_CODE.
//    Only the last 11 bits are used; leading extra bits are ignored.
//  Clock edge and enable-rise in the same sync cycle: the bit is shifted first, then the frame is evaluated.
//  Decode: cmd=sr[8:6], d=sr[5:0].
//    000 mix=d[1:0]; 001 bass=min(d[3:0],12); 010 treble=min(d[3:0],12).
//    011 master=min(d,40); 100 right=min(d[4:0],20); 101 left=min(d[4:0],20).
//    110/111 is accepted but changes no register and still pulses cmd_stb.
//  Timing: the register update and cmd_stb occur on clk32 edge SYNC_STAGES+2 after the MWEN_N pin rise.
//    cmd_stb is high for exactly one cycle. A rejected frame gives no update and no cmd_stb.
//  Gain: per channel, att = (40-master)+(20-chan_vol), range 0..60; q = att/3, r = att%3.
//    coef[r] = {256,203,161}, i.e. 0/-2/-4 dB.
//    s = in - 128 (signed 8b); p = s*coef (17b signed); out = p >>> q (16b).
//    Force 0 when q >= 16.
//  Pipeline: stage1 registers s, coef and q from registers sampled on the audio_stb cycle.
//    Stage2 registers out; audio_vld fires 2 cycles after audio_stb.
//  A register update coincident with audio_stb: that sample uses the OLD values.
//  audio_stb on consecutive cycles is fully pipelined, one output per input.
//  Reset mid-frame: partial frame is discarded. After release, a frame begins only on a fresh MWEN_N fall.
// STRUCTURE
//  Package lmc1992_pkg: command codes, clamp limits (12/40/20), reset values, coef table, ADDR_CODE default.
//  Sub-module lmc_gain_ch: one channel's 2-stage attenuator, instantiated for left and right.
//  Top holds the synchronizers, frame FSM (IDLE/SHIFT/EVAL) and register file.
// TESTING
//  Reset, then audio_stb with 0xFF on both -> 2 cycles later audio_vld=1, out=32512 (0x7F00); status = reset values.
//  Frame 10_011_100000 (11b) -> master_vol=32, single cmd_stb; 16b frame 10110_10_101_001010 -> left_vol=10.
//  Address 01_011_000000 -> no change, no cmd_stb; 10-bit frame -> no change, no cmd_stb.
//  Clamp: master d=63 -> 40; right d=31 -> 20; bass d=15 -> 12.
//  Gain: master=37 (q=1,r=0), in 0xFF -> 16256; master=39 (r=1) -> 25781; in 0x00, att=0 -> -32768.
//  resb low mid-frame after 6 bits -> regs at reset, no cmd_stb; next full frame decodes correctly.

Source files
------------

// File: rtl/lmc1992_pkg.sv
// lmc1992_pkg: shared command codes, clamp limits, reset values and the
// fractional-gain coefficient table for the STE sound-control receiver.
package lmc1992_pkg;

   // Command field sr[8:6] of an accepted frame
   typedef enum logic [2:0] {
      CMD_MIX    = 3'd0,
      CMD_BASS   = 3'd1,
      CMD_TREBLE = 3'd2,
      CMD_MASTER = 3'd3,
      CMD_RIGHT  = 3'd4,
      CMD_LEFT   = 3'd5,
      CMD_NOP6   = 3'd6,
      CMD_NOP7   = 3'd7
   } cmd_e;

   // Frame receiver states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_EVAL  = 2'd2
   } frame_state_e;

   localparam logic [1:0] ADDR_CODE_DEF = 2'b10;

   // Clamp limits
   localparam logic [3:0] TONE_MAX   = 4'd12;
   localparam logic [5:0] MASTER_MAX = 6'd40;
   localparam logic [4:0] CHAN_MAX   = 5'd20;

   // Reset values
   localparam logic [5:0] MASTER_RST = 6'd40;
   localparam logic [4:0] CHAN_RST   = 5'd20;
   localparam logic [3:0] TONE_RST   = 4'd6;
   localparam logic [1:0] MIX_RST    = 2'd1;

   // Minimum number of received bits for a frame to be considered
   localparam logic [4:0] FRAME_BITS = 5'd11;

   // Fine gain step within one 6 dB octave: 0, -2, -4 dB in Q8
   function automatic logic [8:0] coef_lut(input logic [1:0] r);
      logic [8:0] c;
      case (r)
         2'd0:    c = 9'd256;
         2'd1:    c = 9'd203;
         2'd2:    c = 9'd161;
         default: c = 9'd256;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/lmc1992_rx_if.sv
// lmc1992_rx_if: microwire pins plus the DMA audio sample bus of the
// sound-control receiver. The master side drives frames and samples,
// the slave side (the receiver) returns attenuated samples.
interface lmc1992_rx_if;
   logic        MWCLK;
   logic        MWDATA;
   logic        MWEN_N;
   logic        audio_stb;
   logic [7:0]  audio_in_l;
   logic [7:0]  audio_in_r;
   logic [15:0] audio_out_l;
   logic [15:0] audio_out_r;
   logic        audio_vld;

   modport master (
      output MWCLK, MWDATA, MWEN_N, audio_stb, audio_in_l, audio_in_r,
      input  audio_out_l, audio_out_r, audio_vld
   );

   modport slave (
      input  MWCLK, MWDATA, MWEN_N, audio_stb, audio_in_l, audio_in_r,
      output audio_out_l, audio_out_r, audio_vld
   );
endinterface

// File: rtl/lmc1992_rx_gain_ch.sv
// lmc_gain_ch: one channel's two-stage attenuator. Attenuation in 2 dB
// steps is split into a 6 dB shift count (q) and a fine coefficient (r).
module lmc_gain_ch
   import lmc1992_pkg::*;
(
   input  logic        clk32,
   input  logic        resb,
   input  logic        stb_i,
   input  logic [7:0]  sample_i,
   input  logic [5:0]  master_i,
   input  logic [4:0]  chan_vol_i,
   output logic [15:0] out_o,
   output logic        vld_o
);

   logic [5:0]         att_s;
   logic [4:0]         q_s;
   logic [1:0]         r_s;

   logic signed [7:0]  s1_q;
   logic [8:0]         coef1_q;
   logic [4:0]         q1_q;
   logic               vld1_q;

   logic signed [16:0] s_ext_s;
   logic signed [16:0] coef_ext_s;
   logic signed [16:0] prod_s;
   logic [15:0]        out_d;

   // Total attenuation in 2 dB steps, split into 6 dB shifts and a fine step
   always_comb begin
      att_s = (MASTER_MAX - master_i) + ({1'b0, CHAN_MAX} - {1'b0, chan_vol_i});
      q_s   = 5'(att_s / 6'd3);
      r_s   = 2'(att_s % 6'd3);
   end

   // Stage 1: capture centred sample and gain terms on the strobe cycle
   always_ff @(posedge clk32 or negedge resb) begin
      if (!resb) begin
         s1_q    <= 8'sd0;
         coef1_q <= 9'd0;
         q1_q    <= 5'd0;
         vld1_q  <= 1'b0;
      end else begin
         vld1_q <= stb_i;
         if (stb_i) begin
            s1_q    <= $signed(sample_i ^ 8'h80);
            coef1_q <= coef_lut(r_s);
            q1_q    <= q_s;
         end
      end
   end

   // Scale by the fine coefficient, then shift by whole 6 dB steps
   always_comb begin
      s_ext_s    = 17'(s1_q);
      coef_ext_s = $signed({8'd0, coef1_q});
      prod_s     = s_ext_s * coef_ext_s;
      if (q1_q >= 5'd16) begin
         out_d = 16'd0;
      end else begin
         out_d = 16'(prod_s >>> q1_q);
      end
   end

   // Stage 2: register the attenuated sample and its valid pulse
   always_ff @(posedge clk32 or negedge resb) begin
      if (!resb) begin
         out_o <= 16'd0;
         vld_o <= 1'b0;
      end else begin
         vld_o <= vld1_q;
         if (vld1_q) begin
            out_o <= out_d;
         end
      end
   end

endmodule

// File: rtl/lmc1992_rx.sv
// lmc1992_rx: microwire slave receiving 11-bit LMC1992 commands, holding the
// volume/tone/mixer register file and attenuating the DMA audio stream.
module lmc1992_rx
   import lmc1992_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [1:0]  ADDR_CODE   = ADDR_CODE_DEF
) (
   input  logic        clk32,
   input  logic        resb,
   lmc1992_rx_if.slave bus,
   output logic [5:0]  master_vol,
   output logic [4:0]  left_vol,
   output logic [4:0]  right_vol,
   output logic [3:0]  bass,
   output logic [3:0]  treble,
   output logic [1:0]  mix,
   output logic        cmd_stb
);

   logic [SYNC_STAGES-1:0] mwclk_sync_q;
   logic [SYNC_STAGES-1:0] mwdata_sync_q;
   logic [SYNC_STAGES-1:0] mwen_sync_q;
   logic                   mwclk_prev_q;
   logic                   mwen_prev_q;

   logic                   mwclk_s;
   logic                   mwdata_s;
   logic                   mwen_s;
   logic                   clk_rise_s;
   logic                   en_fall_s;
   logic                   en_rise_s;

   frame_state_e           state_q;
   logic [4:0]             cnt_q;
   logic [10:0]            sr_q;

   logic [5:0]             master_q, master_d;
   logic [4:0]             left_q, left_d;
   logic [4:0]             right_q, right_d;
   logic [3:0]             bass_q, bass_d;
   logic [3:0]             treble_q, treble_d;
   logic [1:0]             mix_q, mix_d;
   logic                   cmd_stb_q;

   cmd_e                   cmd_s;
   logic [5:0]             d_s;
   logic                   frame_ok_s;

   // Synchronize the asynchronous microwire pins. The enable copy resets
   // to "active" so a pin already low at reset release cannot fake a fall.
   always_ff @(posedge clk32 or negedge resb) begin
      if (!resb) begin
         mwclk_sync_q  <= '0;
         mwdata_sync_q <= '0;
         mwen_sync_q   <= '0;
         mwclk_prev_q  <= 1'b0;
         mwen_prev_q   <= 1'b0;
      end else begin
         mwclk_sync_q  <= {mwclk_sync_q[SYNC_STAGES-2:0], bus.MWCLK};
         mwdata_sync_q <= {mwdata_sync_q[SYNC_STAGES-2:0], bus.MWDATA};
         mwen_sync_q   <= {mwen_sync_q[SYNC_STAGES-2:0], bus.MWEN_N};
         mwclk_prev_q  <= mwclk_s;
         mwen_prev_q   <= mwen_s;
      end
   end

   // Edge detection on the synchronized copies
   always_comb begin
      mwclk_s    = mwclk_sync_q[SYNC_STAGES-1];
      mwdata_s   = mwdata_sync_q[SYNC_STAGES-1];
      mwen_s     = mwen_sync_q[SYNC_STAGES-1];
      clk_rise_s = mwclk_s & ~mwclk_prev_q;
      en_fall_s  = ~mwen_s & mwen_prev_q;
      en_rise_s  = mwen_s & ~mwen_prev_q;
   end

   // Frame acceptance and command decode into candidate register values
   always_comb begin
      cmd_s      = cmd_e'(sr_q[8:6]);
      d_s        = sr_q[5:0];
      frame_ok_s = (cnt_q >= FRAME_BITS) && (sr_q[10:9] == ADDR_CODE);
      master_d   = master_q;
      left_d     = left_q;
      right_d    = right_q;
      bass_d     = bass_q;
      treble_d   = treble_q;
      mix_d      = mix_q;
      case (cmd_s)
         CMD_MIX:    mix_d    = d_s[1:0];
         CMD_BASS:   bass_d   = (d_s[3:0] > TONE_MAX) ? TONE_MAX : d_s[3:0];
         CMD_TREBLE: treble_d = (d_s[3:0] > TONE_MAX) ? TONE_MAX : d_s[3:0];
         CMD_MASTER: master_d = (d_s > MASTER_MAX) ? MASTER_MAX : d_s;
         CMD_RIGHT:  right_d  = (d_s[4:0] > CHAN_MAX) ? CHAN_MAX : d_s[4:0];
         CMD_LEFT:   left_d   = (d_s[4:0] > CHAN_MAX) ? CHAN_MAX : d_s[4:0];
         default:    mix_d    = mix_q;
      endcase
   end

   // Frame FSM: collect bits while enabled, then apply one command per frame.
   // A clock edge in the same cycle as the enable rise is shifted before EVAL.
   always_ff @(posedge clk32 or negedge resb) begin
      if (!resb) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 5'd0;
         sr_q      <= 11'd0;
         master_q  <= MASTER_RST;
         left_q    <= CHAN_RST;
         right_q   <= CHAN_RST;
         bass_q    <= TONE_RST;
         treble_q  <= TONE_RST;
         mix_q     <= MIX_RST;
         cmd_stb_q <= 1'b0;
      end else begin
         cmd_stb_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (en_fall_s) begin
                  cnt_q   <= 5'd0;
                  sr_q    <= 11'd0;
                  state_q <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (clk_rise_s) begin
                  sr_q  <= {sr_q[9:0], mwdata_s};
                  cnt_q <= (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
               end
               if (en_rise_s) begin
                  state_q <= ST_EVAL;
               end
            end
            ST_EVAL: begin
               if (frame_ok_s) begin
                  master_q  <= master_d;
                  left_q    <= left_d;
                  right_q   <= right_d;
                  bass_q    <= bass_d;
                  treble_q  <= treble_d;
                  mix_q     <= mix_d;
                  cmd_stb_q <= 1'b1;
               end
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign master_vol = master_q;
   assign left_vol   = left_q;
   assign right_vol  = right_q;
   assign bass       = bass_q;
   assign treble     = treble_q;
   assign mix        = mix_q;
   assign cmd_stb    = cmd_stb_q;

   lmc_gain_ch u_gain_l (
      .clk32      (clk32),
      .resb       (resb),
      .stb_i      (bus.audio_stb),
      .sample_i   (bus.audio_in_l),
      .master_i   (master_q),
      .chan_vol_i (left_q),
      .out_o      (bus.audio_out_l),
      .vld_o      (bus.audio_vld)
   );

   logic unused_vld_r_s;

   lmc_gain_ch u_gain_r (
      .clk32      (clk32),
      .resb       (resb),
      .stb_i      (bus.audio_stb),
      .sample_i   (bus.audio_in_r),
      .master_i   (master_q),
      .chan_vol_i (right_q),
      .out_o      (bus.audio_out_r),
      .vld_o      (unused_vld_r_s)
   );

endmodule
